// File: rtl/traffic_signal_ctrl_pkg.sv
// traffic_pkg: shared types for the intersection controller.
//   light_t : 2-bit lamp code driven to the lamp drivers
//   state_t : controller state, also exported as the 3-bit state_o status code
package traffic_pkg;

  typedef enum logic [1:0] {
    LT_DARK   = 2'b00,
    LT_GREEN  = 2'b01,
    LT_YELLOW = 2'b10,
    LT_RED    = 2'b11
  } light_t;

  localparam int STATE_W = 3;

  // state_o encoding
  typedef enum logic [STATE_W-1:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    FLASH       = 3'd6
  } state_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_signal_ctrl_if.sv
// Controller <-> environment bundle.
//   sensor, flash_en              : requests into the controller
//   highway_signal, farm_signal   : lamp codes out
//   state_o, side_req_o           : status out
// master = environment side (sensor conditioning / status consumer), slave = controller.
interface traffic_signal_ctrl_if;
  import traffic_pkg::*;

  logic                 sensor;
  logic                 flash_en;
  light_t               highway_signal;
  light_t               farm_signal;
  logic [STATE_W-1:0]   state_o;
  logic                 side_req_o;

  modport master (
    output sensor, flash_en,
    input  highway_signal, farm_signal, state_o, side_req_o
  );

  modport slave (
    input  sensor, flash_en,
    output highway_signal, farm_signal, state_o, side_req_o
  );
endinterface

// File: rtl/traffic_signal_ctrl_tick_gen.sv
// tick_gen: timing-tick prescaler.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the tick period (state entry)
//   tick     : one-cycle strobe, first one TICK_DIV cycles after rst/clr
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  // With TICK_DIV=1 cnt is pinned at 0 and tick is permanently high.
  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/traffic_signal_ctrl.sv
// traffic_signal_ctrl: highway/farm-road intersection controller.
//   clk, rst : clock, synchronous active-high reset (wins over flash_en)
//   bus      : slave side of traffic_signal_ctrl_if
//              sensor/flash_en in; lamp codes, state_o, side_req_o out.
// All outputs are decoded from registered state, so they change only on clk edges.
module traffic_signal_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV       = 4,
  parameter int MAIN_GREEN_MIN = 8,
  parameter int YELLOW_T       = 3,
  parameter int ALL_RED_T      = 1,
  parameter int SIDE_GREEN_MIN = 4,
  parameter int SIDE_GREEN_MAX = 10,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_signal_ctrl_if.slave  bus
);
  localparam int MAX_DUR = max_int(max_int(MAIN_GREEN_MIN, YELLOW_T),
                                   max_int(ALL_RED_T, max_int(SIDE_GREEN_MIN, SIDE_GREEN_MAX)));

  if (SIDE_GREEN_MIN > SIDE_GREEN_MAX) begin : g_chk_side
    $error("SIDE_GREEN_MIN exceeds SIDE_GREEN_MAX");
  end
  if (TICK_DIV < 1 || MAIN_GREEN_MIN < 1 || YELLOW_T < 1 || ALL_RED_T < 1 ||
      SIDE_GREEN_MIN < 1) begin : g_chk_min
    $error("all durations and TICK_DIV must be at least 1");
  end
  if (CNT_W < 31 && (MAX_DUR - 1) > (2**CNT_W - 1)) begin : g_chk_cnt
    $error("CNT_W too narrow for the longest phase");
  end

  // Terminal timer values (duration - 1)
  localparam logic [CNT_W-1:0] MG_T    = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] Y_T     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] SGMIN_T = CNT_W'(SIDE_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SGMAX_T = CNT_W'(SIDE_GREEN_MAX - 1);

  state_t           state, state_nxt;
  logic             tick, entry, lit, side_req;
  logic [CNT_W-1:0] tmr, tmr_term;
  light_t           hw, fm;

  // Any state change restarts both the prescaler and the phase timer.
  assign entry = (state_nxt != state);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MAIN_GREEN;
    else     state <= state_nxt;
  end

  // Next state; flash request overrides every phase exit.
  always_comb begin
    state_nxt = state;
    if (bus.flash_en && state != FLASH) begin
      state_nxt = FLASH;
    end else begin
      case (state)
        MAIN_GREEN:  if (tick && tmr >= MG_T && (side_req || bus.sensor)) state_nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (tick && tmr == Y_T)  state_nxt = ALL_RED_A;
        ALL_RED_A:   if (tick && tmr == AR_T) state_nxt = SIDE_GREEN;
        SIDE_GREEN:  if (tick && (tmr == SGMAX_T || (tmr >= SGMIN_T && !bus.sensor)))
                       state_nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (tick && tmr == Y_T)  state_nxt = ALL_RED_B;
        ALL_RED_B:   if (tick && tmr == AR_T) state_nxt = MAIN_GREEN;
        FLASH:       if (!bus.flash_en)       state_nxt = ALL_RED_B;
        default:     state_nxt = MAIN_GREEN;
      endcase
    end
  end

  // Per-state saturation point of the phase timer
  always_comb begin
    tmr_term = '0;
    case (state)
      MAIN_GREEN:              tmr_term = MG_T;
      MAIN_YELLOW, SIDE_YELLOW: tmr_term = Y_T;
      ALL_RED_A, ALL_RED_B:    tmr_term = AR_T;
      SIDE_GREEN:              tmr_term = SGMAX_T;
      default:                 tmr_term = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || entry)                tmr <= '0;
    else if (tick && tmr != tmr_term) tmr <= tmr + 1'b1;
  end

  // Request latch: a one-cycle sensor pulse in MAIN_GREEN is remembered
  // until the side road actually gets its green.
  always_ff @(posedge clk) begin
    if (rst)                                 side_req <= 1'b0;
    else if (entry && state_nxt == SIDE_GREEN) side_req <= 1'b0;
    else if (state == MAIN_GREEN && bus.sensor) side_req <= 1'b1;
  end

  // Flash phase: lit on entry, toggles on each tick while flashing.
  always_ff @(posedge clk) begin
    if (rst)                              lit <= 1'b1;
    else if (entry && state_nxt == FLASH) lit <= 1'b1;
    else if (state == FLASH && tick)      lit <= ~lit;
  end

  // Lamp decode
  always_comb begin
    hw = LT_RED;
    fm = LT_RED;
    case (state)
      MAIN_GREEN:  hw = LT_GREEN;
      MAIN_YELLOW: hw = LT_YELLOW;
      SIDE_GREEN:  fm = LT_GREEN;
      SIDE_YELLOW: fm = LT_YELLOW;
      FLASH: begin
        hw = lit ? LT_YELLOW : LT_DARK;
        fm = lit ? LT_RED    : LT_DARK;
      end
      default: ;
    endcase
  end

  assign bus.highway_signal = hw;
  assign bus.farm_signal    = fm;
  assign bus.state_o        = state;
  assign bus.side_req_o     = side_req;
endmodule
